// File: rtl/ex_issue_buf_pkg.sv
// Shared types for the decode-to-execute issue buffer: unit and occupancy
// encodings, the buffered entry layout and the writeback-hit test.
package ex_issue_buf_pkg;

    localparam int ISSUE_XLEN    = 32;
    localparam int ISSUE_REG_AW  = 5;
    localparam int ISSUE_FUNCT_W = 4;

    typedef enum logic [1:0] {
        UNIT_LOGIC = 2'd0,
        UNIT_ADD   = 2'd1,
        UNIT_SHIFT = 2'd2,
        UNIT_RSVD  = 2'd3
    } unit_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    typedef struct packed {
        logic                     valid;
        unit_e                    unit;
        logic [ISSUE_FUNCT_W-1:0] funct;
        logic [ISSUE_REG_AW-1:0]  rd;
        logic [ISSUE_REG_AW-1:0]  rs1;
        logic [ISSUE_REG_AW-1:0]  rs2;
        logic                     use_imm;
        logic [ISSUE_XLEN-1:0]    op1;
        logic [ISSUE_XLEN-1:0]    op2;
    } issue_entry_t;

    // x0 is hardwired zero, so a writeback addressed to it never refreshes an operand.
    function automatic logic fwd_hit(input logic                    wb_valid,
                                     input logic [ISSUE_REG_AW-1:0] wb_rd,
                                     input logic [ISSUE_REG_AW-1:0] rs);
        return wb_valid && (wb_rd != '0) && (wb_rd == rs);
    endfunction

endpackage

// File: rtl/ex_issue_buf_if.sv
// Decode, writeback-snoop and execute-side signals of the issue buffer.
// master = decode/execute environment, slave = the buffer itself.
interface ex_issue_buf_if #(
    parameter int XLEN    = ex_issue_buf_pkg::ISSUE_XLEN,
    parameter int REG_AW  = ex_issue_buf_pkg::ISSUE_REG_AW,
    parameter int FUNCT_W = ex_issue_buf_pkg::ISSUE_FUNCT_W
);
    logic               flush;
    logic               dec_valid;
    logic               dec_ready;
    logic [1:0]         dec_unit;
    logic [FUNCT_W-1:0] dec_funct;
    logic [REG_AW-1:0]  dec_rd;
    logic [REG_AW-1:0]  dec_rs1;
    logic [REG_AW-1:0]  dec_rs2;
    logic [XLEN-1:0]    dec_rs1_data;
    logic [XLEN-1:0]    dec_rs2_data;
    logic [XLEN-1:0]    dec_imm;
    logic               dec_use_imm;
    logic               wb_valid;
    logic [REG_AW-1:0]  wb_rd;
    logic [XLEN-1:0]    wb_data;
    logic               ex_valid;
    logic               ex_ready;
    logic [1:0]         ex_unit;
    logic [FUNCT_W-1:0] funct;
    logic [REG_AW-1:0]  rd;
    logic [XLEN-1:0]    op1;
    logic [XLEN-1:0]    op2;

    modport master (
        output flush, dec_valid, dec_unit, dec_funct, dec_rd, dec_rs1, dec_rs2,
               dec_rs1_data, dec_rs2_data, dec_imm, dec_use_imm,
               wb_valid, wb_rd, wb_data, ex_ready,
        input  dec_ready, ex_valid, ex_unit, funct, rd, op1, op2
    );

    modport slave (
        input  flush, dec_valid, dec_unit, dec_funct, dec_rd, dec_rs1, dec_rs2,
               dec_rs1_data, dec_rs2_data, dec_imm, dec_use_imm,
               wb_valid, wb_rd, wb_data, ex_ready,
        output dec_ready, ex_valid, ex_unit, funct, rd, op1, op2
    );

endinterface

// File: rtl/ex_issue_buf_fwd_entry.sv
// One issue-buffer slot. Captures a decoded op and keeps its register
// operands current by snooping the writeback bus while the op waits.
module ex_issue_buf_fwd_entry
    import ex_issue_buf_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clr,
    input  logic                     load,
    input  logic                     unload,
    input  issue_entry_t             din,
    input  logic                     wb_valid,
    input  logic [ISSUE_REG_AW-1:0]  wb_rd,
    input  logic [ISSUE_XLEN-1:0]    wb_data,
    output logic                     valid,
    output unit_e                    unit,
    output logic [ISSUE_FUNCT_W-1:0] funct,
    output logic [ISSUE_REG_AW-1:0]  rd,
    output logic [ISSUE_XLEN-1:0]    op1,
    output logic [ISSUE_XLEN-1:0]    op2
);

    issue_entry_t q;
    issue_entry_t nxt;

    // Next contents: new op or held op, refreshed by a writeback hit; immediates are left alone.
    always_comb begin
        nxt = load ? din : q;
        if (fwd_hit(wb_valid, wb_rd, nxt.rs1)) begin
            nxt.op1 = wb_data;
        end
        if (!nxt.use_imm && fwd_hit(wb_valid, wb_rd, nxt.rs2)) begin
            nxt.op2 = wb_data;
        end
        if (load) begin
            nxt.valid = 1'b1;
        end else if (unload) begin
            nxt.valid = 1'b0;
        end
    end

    // Slot register: reset clears everything, flush only drops the valid bit.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            q <= '0;
        end else if (clr) begin
            q.valid <= 1'b0;
        end else begin
            q <= nxt;
        end
    end

    assign valid = q.valid;
    assign unit  = q.unit;
    assign funct = q.funct;
    assign rd    = q.rd;
    assign op1   = q.op1;
    assign op2   = q.op2;

endmodule

// File: rtl/ex_issue_buf.sv
// Two-entry skid buffer between decode and execute. Entries are ping-pong
// slots addressed by a head pointer; outputs come straight from the head slot
// and dec_ready is a register, so ex_ready never reaches decode combinationally.
module ex_issue_buf
    import ex_issue_buf_pkg::*;
#(
    parameter int XLEN    = ISSUE_XLEN,
    parameter int REG_AW  = ISSUE_REG_AW,
    parameter int FUNCT_W = ISSUE_FUNCT_W
)
(
    input  logic         clk_i,
    input  logic         rst_n_i,
    ex_issue_buf_if.slave ib
);

    occ_e               state_q;
    occ_e               state_d;
    logic               head_q;
    logic               ready_q;
    logic               push;
    logic               pop;
    logic               tail;
    logic [1:0]         load;
    logic [1:0]         unload;
    logic [XLEN-1:0]    op2_cap;
    issue_entry_t       cap;

    logic               e_valid [2];
    unit_e              e_unit  [2];
    logic [FUNCT_W-1:0] e_funct [2];
    logic [REG_AW-1:0]  e_rd    [2];
    logic [XLEN-1:0]    e_op1   [2];
    logic [XLEN-1:0]    e_op2   [2];

    assign push = ib.dec_valid & ready_q & ~ib.flush;
    assign pop  = ib.ex_valid & ib.ex_ready & ~ib.flush;

    assign op2_cap = ib.dec_use_imm ? ib.dec_imm : ib.dec_rs2_data;

    // Assemble the incoming op with its operand selection.
    always_comb begin
        cap         = '0;
        cap.valid   = 1'b1;
        cap.unit    = unit_e'(ib.dec_unit);
        cap.funct   = ib.dec_funct;
        cap.rd      = ib.dec_rd;
        cap.rs1     = ib.dec_rs1;
        cap.rs2     = ib.dec_rs2;
        cap.use_imm = ib.dec_use_imm;
        cap.op1     = ib.dec_rs1_data;
        cap.op2     = op2_cap;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        ex_issue_buf_fwd_entry u_entry (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .clr      (ib.flush),
            .load     (load[gi]),
            .unload   (unload[gi]),
            .din      (cap),
            .wb_valid (ib.wb_valid),
            .wb_rd    (ib.wb_rd),
            .wb_data  (ib.wb_data),
            .valid    (e_valid[gi]),
            .unit     (e_unit[gi]),
            .funct    (e_funct[gi]),
            .rd       (e_rd[gi]),
            .op1      (e_op1[gi]),
            .op2      (e_op2[gi])
        );
    end

    // Occupancy state, head pointer and registered ready; flush returns to empty.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || ib.flush) begin
            state_q <= OCC_EMPTY;
            head_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            head_q  <= head_q ^ pop;
            ready_q <= (state_d != OCC_FULL);
        end
    end

    // Occupancy transitions from push/pop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OCC_EMPTY: if (push) state_d = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop)      state_d = OCC_FULL;
                else if (pop && !push) state_d = OCC_EMPTY;
            end
            OCC_FULL:  if (pop) state_d = OCC_ONE;
            default:   state_d = OCC_EMPTY;
        endcase
    end

    // Slot enables: an empty buffer writes at head, otherwise at the other slot.
    always_comb begin
        tail         = (state_q == OCC_EMPTY) ? head_q : ~head_q;
        load         = '0;
        unload       = '0;
        load[tail]   = push;
        unload[head_q] = pop;
    end

    assign ib.dec_ready = ready_q;
    assign ib.ex_valid  = head_q ? e_valid[1] : e_valid[0];
    assign ib.ex_unit   = head_q ? e_unit[1]  : e_unit[0];
    assign ib.funct     = head_q ? e_funct[1] : e_funct[0];
    assign ib.rd        = head_q ? e_rd[1]    : e_rd[0];
    assign ib.op1       = head_q ? e_op1[1]   : e_op1[0];
    assign ib.op2       = head_q ? e_op2[1]   : e_op2[0];

endmodule

// File: tb/tb_ex_issue_buf.sv
// Bench for ex_issue_buf: directed scenarios followed by random traffic,
// all compared against a queue-based model of the issue buffer.
module tb_ex_issue_buf;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ex_issue_buf_if bif ();

    ex_issue_buf dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .ib      (bif)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0]  unit;
        logic [3:0]  funct;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use_imm;
        logic [31:0] op1;
        logic [31:0] op2;
    } op_t;

    op_t  mq[$];
    logic m_ready = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic hit(input logic [4:0] rs);
        return bif.wb_valid && (bif.wb_rd != 5'd0) && (bif.wb_rd == rs);
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        op_t n;
        logic do_pop, do_push;
        if (!rst_n || bif.flush) begin
            mq.delete();
            m_ready = 1'b1;
            return;
        end
        do_pop  = (mq.size() > 0) && bif.ex_ready;
        do_push = bif.dec_valid && m_ready;
        if (do_pop) void'(mq.pop_front());
        foreach (mq[i]) begin
            if (hit(mq[i].rs1)) mq[i].op1 = bif.wb_data;
            if (!mq[i].use_imm && hit(mq[i].rs2)) mq[i].op2 = bif.wb_data;
        end
        if (do_push) begin
            n.unit    = bif.dec_unit;
            n.funct   = bif.dec_funct;
            n.rd      = bif.dec_rd;
            n.rs1     = bif.dec_rs1;
            n.rs2     = bif.dec_rs2;
            n.use_imm = bif.dec_use_imm;
            n.op1     = hit(bif.dec_rs1) ? bif.wb_data : bif.dec_rs1_data;
            if (bif.dec_use_imm)     n.op2 = bif.dec_imm;
            else if (hit(bif.dec_rs2)) n.op2 = bif.wb_data;
            else                     n.op2 = bif.dec_rs2_data;
            mq.push_back(n);
        end
        m_ready = (mq.size() < 2);
    endtask

    task automatic check_out();
        chk("ex_valid", {31'd0, bif.ex_valid}, {31'd0, (mq.size() > 0)});
        chk("dec_ready", {31'd0, bif.dec_ready}, {31'd0, m_ready});
        if (mq.size() > 0) begin
            chk("rd", {27'd0, bif.rd}, {27'd0, mq[0].rd});
            chk("op1", bif.op1, mq[0].op1);
            chk("op2", bif.op2, mq[0].op2);
            chk("funct", {28'd0, bif.funct}, {28'd0, mq[0].funct});
            chk("unit", {30'd0, bif.ex_unit}, {30'd0, mq[0].unit});
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    task automatic idle_in();
        bif.flush        = 1'b0;
        bif.dec_valid    = 1'b0;
        bif.dec_unit     = 2'd0;
        bif.dec_funct    = 4'd0;
        bif.dec_rd       = 5'd0;
        bif.dec_rs1      = 5'd0;
        bif.dec_rs2      = 5'd0;
        bif.dec_rs1_data = 32'd0;
        bif.dec_rs2_data = 32'd0;
        bif.dec_imm      = 32'd0;
        bif.dec_use_imm  = 1'b0;
        bif.wb_valid     = 1'b0;
        bif.wb_rd        = 5'd0;
        bif.wb_data      = 32'd0;
        bif.ex_ready     = 1'b0;
    endtask

    task automatic drive_op(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm, input logic use_imm);
        bif.dec_valid    = 1'b1;
        bif.dec_unit     = rd[1:0];
        bif.dec_funct    = {rd[3:0]};
        bif.dec_rd       = rd;
        bif.dec_rs1      = rs1;
        bif.dec_rs2      = rs2;
        bif.dec_rs1_data = d1;
        bif.dec_rs2_data = d2;
        bif.dec_imm      = imm;
        bif.dec_use_imm  = use_imm;
    endtask

    task automatic drain();
        bif.dec_valid = 1'b0;
        bif.wb_valid  = 1'b0;
        bif.ex_ready  = 1'b1;
        repeat (3) cycle();
        bif.ex_ready  = 1'b0;
    endtask

    initial begin
        idle_in();
        // Reset held with decode asserting valid: nothing may be accepted.
        rst_n = 1'b0;
        drive_op(5'd9, 5'd1, 5'd2, 32'h1111_1111, 32'h2222_2222, 32'd0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_ex_valid", {31'd0, bif.ex_valid}, 32'd0);
            chk("rst_dec_ready", {31'd0, bif.dec_ready}, 32'd1);
            chk("rst_op1", bif.op1, 32'd0);
            chk("rst_op2", bif.op2, 32'd0);
        end
        idle_in();
        rst_n = 1'b1;
        cycle();

        // Streaming with execute always ready.
        bif.ex_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive_op(5'(i), 5'd0, 5'd0, 32'(i * 16), 32'(i * 256), 32'd0, 1'b0);
            cycle();
            chk("stream_ready", {31'd0, bif.dec_ready}, 32'd1);
            chk("stream_rd", {27'd0, bif.rd}, 32'(i));
        end
        drain();

        // Backpressure: third op waits for space.
        for (int i = 10; i <= 12; i++) begin
            drive_op(5'(i), 5'd0, 5'd0, 32'(i), 32'(i), 32'd0, 1'b0);
            cycle();
            if (i == 11) chk("bp_ready_full", {31'd0, bif.dec_ready}, 32'd0);
        end
        bif.ex_ready = 1'b1;
        cycle();
        cycle();
        drain();

        // Forward into a held rs1, then the same with x0.
        drive_op(5'd7, 5'd5, 5'd9, 32'd0, 32'h1234, 32'd0, 1'b0);
        cycle();
        bif.dec_valid = 1'b0;
        bif.wb_valid = 1'b1; bif.wb_rd = 5'd5; bif.wb_data = 32'hDEAD_BEEF;
        cycle();
        chk("fwd_op1", bif.op1, 32'hDEAD_BEEF);
        drain();
        drive_op(5'd7, 5'd0, 5'd9, 32'd0, 32'h1234, 32'd0, 1'b0);
        cycle();
        bif.dec_valid = 1'b0;
        bif.wb_valid = 1'b1; bif.wb_rd = 5'd0; bif.wb_data = 32'hDEAD_BEEF;
        cycle();
        chk("fwd_x0_op1", bif.op1, 32'd0);
        drain();

        // Immediate operand is never refreshed.
        drive_op(5'd3, 5'd1, 5'd6, 32'd0, 32'h55, 32'h7FF, 1'b1);
        cycle();
        bif.dec_valid = 1'b0;
        bif.wb_valid = 1'b1; bif.wb_rd = 5'd6; bif.wb_data = 32'hCAFE_F00D;
        cycle();
        chk("imm_op2", bif.op2, 32'h0000_07FF);
        drain();

        // Flush a full buffer while push and pop are also requested.
        drive_op(5'd21, 5'd0, 5'd0, 32'd1, 32'd2, 32'd0, 1'b0);
        cycle();
        drive_op(5'd22, 5'd0, 5'd0, 32'd3, 32'd4, 32'd0, 1'b0);
        cycle();
        drive_op(5'd20, 5'd0, 5'd0, 32'd5, 32'd6, 32'd0, 1'b0);
        bif.flush = 1'b1;
        bif.ex_ready = 1'b1;
        cycle();
        chk("flush_ex_valid", {31'd0, bif.ex_valid}, 32'd0);
        chk("flush_dec_ready", {31'd0, bif.dec_ready}, 32'd1);
        bif.flush = 1'b0;
        bif.dec_valid = 1'b0;
        repeat (2) cycle();

        // Random traffic with a reset in the middle.
        for (int c = 0; c < 400; c++) begin
            drive_op(5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
            bif.dec_unit  = 2'($urandom_range(0, 3));
            bif.dec_funct = 4'($urandom_range(0, 15));
            bif.dec_valid = ($urandom_range(0, 3) != 0);
            bif.ex_ready  = ($urandom_range(0, 2) != 0);
            bif.wb_valid  = ($urandom_range(0, 1) != 0);
            bif.wb_rd     = 5'($urandom_range(0, 7));
            bif.wb_data   = $urandom;
            bif.flush     = ($urandom_range(0, 19) == 0);
            rst_n         = (c != 200);
            cycle();
        end
        rst_n = 1'b1;
        idle_in();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
